// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchronizer, mid-bit oversampling FSM,
// and a one-deep valid/ready output buffer that reports framing errors and overruns.
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       ap_rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       ap_valid,
   input  logic       ap_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    idx_r;
   logic [7:0]    shift_r;
   logic          dlv_r;
   logic          ferr_r;
   logic          rx_meta_r;
   logic          rx_s;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         rx_meta_r <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_s      <= rx_meta_r;
      end
   end

   // Receive FSM: busy mirrors the next state, dlv_r/ferr_r strobe at the stop sample.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         state_r <= IDLE;
         cnt_r   <= CW'(0);
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         dlv_r   <= 1'b0;
         ferr_r  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         dlv_r  <= 1'b0;
         ferr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_r <= START;
                  cnt_r   <= CW'(0);
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            START: begin
               if (cnt_r == HALF_M1) begin
                  cnt_r <= CW'(0);
                  if (rx_s) begin
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     state_r <= DATA;
                     idx_r   <= 3'd0;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DATA: begin
               if (cnt_r == BIT_M1) begin
                  cnt_r          <= CW'(0);
                  shift_r[idx_r] <= rx_s;
                  if (idx_r == 3'd7) begin
                     state_r <= STOP;
                  end else begin
                     idx_r <= idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            STOP: begin
               if (cnt_r == BIT_M1) begin
                  cnt_r <= CW'(0);
                  if (rx_s) begin
                     dlv_r   <= 1'b1;
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     ferr_r  <= 1'b1;
                     state_r <= BRK;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            BRK: begin
               // A held-low line (break) must rise before a new start is accepted.
               if (rx_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r <= BRK;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CW'(0);
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Output buffer: a delivery coinciding with a handshake replaces the byte without overrun.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         data_out  <= 8'h00;
         ap_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_r;
         overrun   <= 1'b0;
         if (dlv_r) begin
            if (ap_valid && !ap_ready) begin
               overrun <= 1'b1;
            end else begin
               data_out <= shift_r;
               ap_valid <= 1'b1;
            end
         end else if (ap_valid && ap_ready) begin
            ap_valid <= 1'b0;
         end else begin
            ap_valid <= ap_valid;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, expected bytes
// queued on send and compared when the consumer handshake fires.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       ap_rst = 1'b1;
   logic       rx = 1'b0;
   logic       ap_ready = 1'b0;
   logic [7:0] data_out;
   logic       ap_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .ap_rst    (ap_rst),
      .rx        (rx),
      .data_out  (data_out),
      .ap_valid  (ap_valid),
      .ap_ready  (ap_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_pass = 0;
   int         n_fail = 0;
   int         n_total = 0;
   logic [7:0] exp_q[$];
   int         hs_cnt = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   int         rise_cyc = -1;
   logic       prev_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [9:0] fr, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         rx = fr[i / CPB];
         tick();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      send_bits({stop_bit, b, 1'b0}, 10 * CPB);
   endtask

   task automatic ready_pulse();
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      tick();
   endtask

   // Monitor: pulse counters, ap_valid rise time, and scoreboard pop on each handshake.
   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (ap_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      prev_valid = ap_valid;
      if (ap_valid === 1'b1 && ap_ready === 1'b1) begin
         hs_cnt++;
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      int c0;
      int hs0;
      int f0;
      int o0;
      logic [7:0] bb [3];
      bb = '{8'h00, 8'hFF, 8'h3C};

      // Reset held with rx low, released with rx high.
      repeat (3) tick();
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_valid", 32'(ap_valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_ovr", 32'(overrun), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rx = 1'b1;
      ap_rst = 1'b0;
      repeat (20) tick();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_valid", 32'(ap_valid), 32'h0);

      // Single byte with latency measurement and hold until ready.
      c0 = cyc;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      repeat (20) tick();
      chk("a5_latency", 32'(rise_cyc - c0), 32'd156);
      chk("a5_valid", 32'(ap_valid), 32'h1);
      chk("a5_data", 32'(data_out), 32'hA5);
      repeat (30) tick();
      chk("a5_hold_valid", 32'(ap_valid), 32'h1);
      chk("a5_hold_data", 32'(data_out), 32'hA5);
      ready_pulse();
      chk("a5_cleared", 32'(ap_valid), 32'h0);
      chk("a5_hs", 32'(hs_cnt), 32'd1);

      // Back-to-back frames with consumer always ready.
      ap_ready = 1'b1;
      hs0 = hs_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(bb[i]);
         send_byte(bb[i], 1'b1);
      end
      repeat (20) tick();
      ap_ready = 1'b0;
      chk("b2b_hs", 32'(hs_cnt - hs0), 32'd3);
      chk("b2b_q", 32'(exp_q.size()), 32'd0);
      chk("b2b_ferr", 32'(ferr_cnt), 32'd0);
      chk("b2b_ovr", 32'(ovr_cnt), 32'd0);

      // Overrun: second byte dropped, first held.
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (20) tick();
      chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
      chk("ovr_data", 32'(data_out), 32'h11);
      chk("ovr_valid", 32'(ap_valid), 32'h1);
      ready_pulse();
      chk("ovr_q", 32'(exp_q.size()), 32'd0);

      // Handshake on the very delivery cycle of the second byte: no overrun.
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      fork
         send_byte(8'h22, 1'b1);
         begin
            repeat (155) tick();
            ap_ready = 1'b1;
            tick();
            ap_ready = 1'b0;
         end
      join
      repeat (5) tick();
      chk("same_cyc_ovr", 32'(ovr_cnt), 32'd1);
      chk("same_cyc_data", 32'(data_out), 32'h22);
      chk("same_cyc_valid", 32'(ap_valid), 32'h1);
      ready_pulse();
      chk("same_cyc_q", 32'(exp_q.size()), 32'd0);

      // Framing error with the line held low afterwards.
      f0 = ferr_cnt;
      hs0 = hs_cnt;
      send_byte(8'h5A, 1'b0);
      repeat (40) tick();
      chk("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
      chk("ferr_valid", 32'(ap_valid), 32'h0);
      chk("ferr_busy_brk", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (6) tick();
      chk("ferr_busy_end", 32'(busy), 32'h0);

      // Short low glitch on an idle line.
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (2) tick();
      chk("glitch_busy", 32'(busy), 32'h1);
      repeat (20) tick();
      chk("glitch_idle", 32'(busy), 32'h0);
      chk("glitch_valid", 32'(ap_valid), 32'h0);
      chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("glitch_ovr", 32'(ovr_cnt - o0), 32'd0);
      chk("glitch_hs", 32'(hs_cnt - hs0), 32'd0);

      // Reset in the middle of data bit 4, then a clean frame.
      ap_ready = 1'b1;
      hs0 = hs_cnt;
      send_bits({1'b1, 8'h77, 1'b0}, 5 * CPB + 8);
      ap_rst = 1'b1;
      rx = 1'b1;
      repeat (2) tick();
      ap_rst = 1'b0;
      repeat (20) tick();
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_valid", 32'(ap_valid), 32'h0);
      chk("mid_rst_hs", 32'(hs_cnt - hs0), 32'd0);
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1);
      repeat (20) tick();
      chk("after_rst_hs", 32'(hs_cnt - hs0), 32'd1);
      chk("after_rst_q", 32'(exp_q.size()), 32'd0);
      chk("after_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("after_rst_ovr", 32'(ovr_cnt - o0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
